// File: rtl/l17_pkg.sv
// Shared definitions for the layer-17 loop-nest sequencer: FSM encoding and R-counter constants.
package l17_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWaitR,
    StFin
  } l17_state_e;

  localparam logic [2:0] U_SKIP_A = 3'd3;
  localparam logic [2:0] U_SKIP_B = 3'd4;
  localparam logic [2:0] R_LAST   = 3'd5;

  // The R counter starts a burst on any strobe, except an L_zero alone in u phase 3 or 4.
  function automatic logic r_burst(input logic k_wrap, input logic j_wrap, input logic l_wrap,
                                   input logic [2:0] u_pre);
    return k_wrap | j_wrap | (l_wrap & (u_pre != U_SKIP_A) & (u_pre != U_SKIP_B));
  endfunction

endpackage

// File: rtl/l17_wrap_counter.sv
// Modulo-N index counter with synchronous clear and a same-cycle wrap indication.
module l17_wrap_counter #(
  parameter int unsigned N = 2,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] idx_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] Max = W'(N - 1);

  logic [W-1:0] idx_q, idx_d;

  assign wrap_o = inc_i && (idx_q == Max);

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = wrap_o ? '0 : idx_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/l17_loop_sequencer.sv
// Layer-17 loop-nest initiator: walks k/j/L/u, emits wrap strobes and waits on R_zero per burst.
module l17_loop_sequencer
  import l17_pkg::*;
#(
  parameter int unsigned K_COUNT  = 32,
  parameter int unsigned J_COUNT  = 16,
  parameter int unsigned L_COUNT  = 8,
  parameter int unsigned U_PHASES = 5,
  parameter int unsigned R_TMO    = 15,
  localparam int unsigned KW = (K_COUNT > 1) ? $clog2(K_COUNT) : 1,
  localparam int unsigned JW = (J_COUNT > 1) ? $clog2(J_COUNT) : 1,
  localparam int unsigned LW = (L_COUNT > 1) ? $clog2(L_COUNT) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          r_zero_i,
  output logic          k_zero_o,
  output logic          j_zero_o,
  output logic          l_zero_o,
  output logic [2:0]    u_o,
  output logic [KW-1:0] k_idx_o,
  output logic [JW-1:0] j_idx_o,
  output logic [LW-1:0] l_idx_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int unsigned TW = $clog2(R_TMO + 1);

  l17_state_e    state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    u_q, u_d;
  logic          k_zero_q, j_zero_q, l_zero_q;
  logic          run, clr, k_wrap, j_wrap, l_wrap, last, burst;

  assign run   = (state_q == StRun);
  assign clr   = (state_q == StIdle) && start_i;
  assign last  = l_wrap && (u_q == 3'(U_PHASES - 1));
  assign burst = r_burst(k_wrap, j_wrap, l_wrap, u_q);

  l17_wrap_counter #(.N(K_COUNT), .W(KW)) u_k_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (run),
    .clr_i  (clr),
    .idx_o  (k_idx_o),
    .wrap_o (k_wrap)
  );

  l17_wrap_counter #(.N(J_COUNT), .W(JW)) u_j_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (k_wrap),
    .clr_i  (clr),
    .idx_o  (j_idx_o),
    .wrap_o (j_wrap)
  );

  l17_wrap_counter #(.N(L_COUNT), .W(LW)) u_l_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (j_wrap),
    .clr_i  (clr),
    .idx_o  (l_idx_o),
    .wrap_o (l_wrap)
  );

  always_comb begin
    u_d = u_q;
    if (clr) begin
      u_d = '0;
    end else if (l_wrap && !last) begin
      u_d = u_q + 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      StRun: begin
        if (r_zero_i) err_d = 1'b1;
        // Final wrap skips WAIT_R; its trailing R_zero lands in FIN/IDLE and is ignored.
        if (last) begin
          state_d = StFin;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (burst) begin
          state_d = StWaitR;
          timer_d = TW'(1);
        end
      end
      StWaitR: begin
        if (r_zero_i) begin
          state_d = StRun;
        end else if (timer_q == TW'(R_TMO)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      u_q      <= '0;
      k_zero_q <= 1'b0;
      j_zero_q <= 1'b0;
      l_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      u_q      <= u_d;
      k_zero_q <= k_wrap;
      j_zero_q <= j_wrap;
      l_zero_q <= l_wrap;
    end
  end

  assign k_zero_o = k_zero_q;
  assign j_zero_o = j_zero_q;
  assign l_zero_o = l_zero_q;
  assign u_o      = u_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_l17_loop_sequencer.sv
// Directed bench for l17_loop_sequencer with K=J=L=2, U=5 and a behavioural R counter.
module tb_l17_loop_sequencer;
  import l17_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       r_zero;
  logic       k_zero, j_zero, l_zero, busy, done, err;
  logic [2:0] u;
  logic       k_idx, j_idx, l_idx;

  logic       suppress = 1'b0;
  logic       inject = 1'b0;
  logic [2:0] r_cnt;

  int n_chk = 0;
  int n_bad = 0;
  int cyc, n_k, n_j, n_l, n_wait, n_done, done_cyc;
  logic [2:0] lz_u [8];
  logic [7:0] lz_busy;

  always #5 clk = ~clk;

  l17_loop_sequencer #(
    .K_COUNT(2), .J_COUNT(2), .L_COUNT(2), .U_PHASES(5), .R_TMO(15)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .r_zero_i(r_zero),
    .k_zero_o(k_zero),
    .j_zero_o(j_zero),
    .l_zero_o(l_zero),
    .u_o     (u),
    .k_idx_o (k_idx),
    .j_idx_o (j_idx),
    .l_idx_o (l_idx),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err)
  );

  // R counter model: R_zero R_LAST cycles after any strobe cycle.
  always @(posedge clk) begin
    if (rst) r_cnt <= 3'd0;
    else if (k_zero || j_zero || l_zero) r_cnt <= 3'd1;
    else if (r_cnt != 3'd0 && r_cnt < R_LAST) r_cnt <= r_cnt + 3'd1;
    else r_cnt <= 3'd0;
  end
  assign r_zero = ((r_cnt == R_LAST) && !suppress) || inject;

  task automatic clear_counts();
    cyc = 0; n_k = 0; n_j = 0; n_l = 0; n_wait = 0; n_done = 0; done_cyc = 0; lz_busy = '0;
    for (int i = 0; i < 8; i++) lz_u[i] = 3'd0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (k_zero) n_k++;
    if (j_zero) n_j++;
    if (l_zero) begin
      if (n_l < 8) begin lz_u[n_l] = u; lz_busy[n_l] = busy; end
      n_l++;
    end
    if (k_zero && busy) n_wait++;
    if (done) begin n_done++; if (done_cyc == 0) done_cyc = cyc; end
  endtask

  // Start pulse spans one edge; returns at the first cycle after acceptance.
  task automatic pulse_start();
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done();
    int b = 0;
    while (!done && b < 400) begin tick(); b++; end
    n_chk++;
    if (!done) begin
      n_bad++; $display("FAIL run_done: done=%0b after %0d cycles, required 1", done, b);
    end
    repeat (10) tick();
  endtask

  task automatic test_reset();
    clear_counts();
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    n_chk++;
    if ({k_zero, j_zero, l_zero, done, err, u, k_idx, j_idx, l_idx} !== 11'd0) begin
      n_bad++; $display("FAIL reset_outs: got %b, required 0",
                        {k_zero, j_zero, l_zero, done, err, u, k_idx, j_idx, l_idx});
    end
    n_chk++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_chk++;
    if (n_k + n_j + n_l + n_done !== 0) begin
      n_bad++; $display("FAIL reset_idle_strobes: got %0d, required 0", n_k + n_j + n_l + n_done);
    end
  endtask

  task automatic test_full_run();
    pulse_start();
    n_chk++;
    if ({busy, k_idx, k_zero} !== 3'b100) begin
      n_bad++; $display("FAIL lat_t1: busy/k/kz=%b, required 100", {busy, k_idx, k_zero});
    end
    tick();
    n_chk++;
    if ({k_idx, k_zero} !== 2'b10) begin
      n_bad++; $display("FAIL lat_t2: k/kz=%b, required 10", {k_idx, k_zero});
    end
    tick();
    n_chk++;
    if ({k_zero, j_zero, k_idx, j_idx} !== 4'b1001) begin
      n_bad++; $display("FAIL first_kzero: kz/jz/k/j=%b, required 1001",
                        {k_zero, j_zero, k_idx, j_idx});
    end
    run_until_done();
    n_chk++;
    if (done_cyc !== 155) begin n_bad++; $display("FAIL done_cycle: got %0d, required 155", done_cyc); end
    n_chk++;
    if (n_k !== 20 || n_j !== 10 || n_l !== 5) begin
      n_bad++; $display("FAIL strobe_counts: k=%0d j=%0d l=%0d, required 20 10 5", n_k, n_j, n_l);
    end
    n_chk++;
    if (n_wait !== 19) begin n_bad++; $display("FAIL wait_episodes: got %0d, required 19", n_wait); end
    n_chk++;
    if (n_done !== 1 || err !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL full_end: done=%0d err=%b busy=%b, required 1 0 0", n_done, err, busy);
    end
    // u seen after each L wrap is post-increment; last wrap holds u=4 and skips WAIT_R.
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (lz_u[i] !== ((i < 4) ? 3'(i + 1) : 3'd4) || lz_busy[i] !== (i < 4)) begin
        n_bad++; $display("FAIL lzero_%0d: u=%0d busy=%b, required u=%0d busy=%b", i, lz_u[i],
                          lz_busy[i], (i < 4) ? i + 1 : 4, (i < 4));
      end
    end
  endtask

  task automatic test_timeout();
    suppress = 1'b1;
    pulse_start();
    repeat (16) tick();
    n_chk++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      n_bad++; $display("FAIL tmo_last_wait: busy=%b err=%b, required 1 0", busy, err);
    end
    tick();
    n_chk++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      n_bad++; $display("FAIL tmo_idle: busy=%b err=%b, required 0 1", busy, err);
    end
    suppress = 1'b0;
    repeat (10) tick();
    n_chk++;
    if (n_done !== 0 || err !== 1'b1) begin
      n_bad++; $display("FAIL tmo_sticky: done=%0d err=%b, required 0 1", n_done, err);
    end
    pulse_start();
    n_chk++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_clear: err=%b, required 0", err); end
    run_until_done();
    n_chk++;
    if (n_done !== 1 || done_cyc !== 155 || err !== 1'b0) begin
      n_bad++; $display("FAIL tmo_rerun: done=%0d at %0d err=%b, required 1 at 155 err 0",
                        n_done, done_cyc, err);
    end
  endtask

  task automatic test_inject();
    pulse_start();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    n_chk++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL inject_err: err=%b busy=%b, required 1 1", err, busy);
    end
    run_until_done();
    n_chk++;
    if (n_done !== 1 || done_cyc !== 155 || err !== 1'b1) begin
      n_bad++; $display("FAIL inject_run: done=%0d at %0d err=%b, required 1 at 155 err 1",
                        n_done, done_cyc, err);
    end
  endtask

  task automatic test_rst_mid();
    pulse_start();
    repeat (29) tick();
    n_chk++;
    if (busy !== 1'b1 || k_zero !== 1'b0) begin
      n_bad++; $display("FAIL rst_pre: busy=%b kz=%b, required 1 0", busy, k_zero);
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if ({busy, done, err, k_zero, j_zero, l_zero, u, k_idx, j_idx, l_idx} !== 12'd0) begin
      n_bad++; $display("FAIL rst_mid: got %b, required 0",
                        {busy, done, err, k_zero, j_zero, l_zero, u, k_idx, j_idx, l_idx});
    end
    rst = 1'b0;
    repeat (20) tick();
    n_chk++;
    if (n_done !== 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_no_done: done=%0d busy=%b, required 0 0", n_done, busy);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done();
    repeat (20) tick();
    n_chk++;
    if (n_done !== 1 || done_cyc !== 155 || busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_start: done=%0d at %0d busy=%b, required 1 at 155 busy 0",
                        n_done, done_cyc, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_timeout();
    test_inject();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
